// File: rtl/clock_phase_tracker_pkg.sv
// Types shared by the divided-clock phase tracker and the clock divider that
// produces clkIn, so both ends agree on the ratio.
package Types;

   localparam int CLOCK_DIV_RATIO = 4;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } ClockTrackerState;

   function automatic logic [7:0] satInc8(input logic [7:0] value);
      satInc8 = (value == 8'hFF) ? value : value + 8'h01;
   endfunction

endpackage

// File: rtl/clock_phase_tracker_edge.sv
// Edge detector for the sampled divided clock: keeps one cycle of history
// and flags 0->1 and 1->0 transitions of the current sample.
module ClockEdgeDetect (
   input  logic clkX4,
   input  logic rst,
   input  logic sample,
   output logic rise,
   output logic fall
);

   logic prev;

   // one-cycle history of the sampled level
   always_ff @(posedge clkX4) begin
      if (rst) begin
         prev <= 1'b0;
      end else begin
         prev <= sample;
      end
   end

   assign rise = sample & ~prev;
   assign fall = ~sample & prev;

endmodule

// File: rtl/clock_phase_tracker.sv
// Recovers the phase of the divided clock clkIn in the clkX4 domain, emits
// edge strobes, declares lock after clean periods and counts locked glitches.
module clock_phase_tracker
   import Types::*;
#(
   parameter int DIV_RATIO    = CLOCK_DIV_RATIO,
   parameter int HIGH_PHASES  = 2,
   parameter int LOCK_PERIODS = 2
) (
   input  logic                         clkX4,
   input  logic                         rst,
   input  logic                         clkIn,
   output logic [$clog2(DIV_RATIO)-1:0] phase,
   output logic                         risePulse,
   output logic                         fallPulse,
   output logic                         locked,
   output logic                         errorPulse,
   output logic [7:0]                   errCount
);

   localparam int PW = $clog2(DIV_RATIO);
   localparam int GW = $clog2(LOCK_PERIODS + 1);
   localparam logic [PW-1:0] LAST_PHASE  = PW'(DIV_RATIO - 1);
   localparam logic [PW-1:0] HIGH_LIMIT  = PW'(HIGH_PHASES);
   localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_PERIODS);

   ClockTrackerState state;
   ClockTrackerState nextState;
   logic [PW-1:0]    phaseCnt;
   logic [PW-1:0]    nextPhaseCnt;
   logic [PW-1:0]    advPhase;
   logic [PW-1:0]    reportPhase;
   logic [GW-1:0]    goodCnt;
   logic [GW-1:0]    nextGoodCnt;
   logic             rise;
   logic             fall;
   logic             expectedLevel;
   logic             mismatch;
   logic             lockErr;

   ClockEdgeDetect edgeDetect (
      .clkX4  (clkX4),
      .rst    (rst),
      .sample (clkIn),
      .rise   (rise),
      .fall   (fall)
   );

   // phaseCnt is the phase of the sample being taken this cycle
   always_comb begin
      nextState     = state;
      nextPhaseCnt  = phaseCnt;
      nextGoodCnt   = goodCnt;
      reportPhase   = '0;
      lockErr       = 1'b0;
      expectedLevel = (phaseCnt < HIGH_LIMIT);
      mismatch      = (clkIn != expectedLevel) || (rise && (phaseCnt != '0));
      advPhase      = (phaseCnt == LAST_PHASE) ? '0 : phaseCnt + PW'(1);

      case (state)
         SEARCH: begin
            if (rise) begin
               nextState    = ACQUIRE;
               nextPhaseCnt = PW'(1);
               nextGoodCnt  = '0;
            end else begin
               nextState    = SEARCH;
            end
         end
         ACQUIRE, LOCKED: begin
            reportPhase  = phaseCnt;
            nextPhaseCnt = advPhase;
            if (mismatch) begin
               lockErr = (state == LOCKED);
               if (rise) begin
                  // early rise: treat it as the new phase 0
                  nextState    = ACQUIRE;
                  reportPhase  = '0;
                  nextPhaseCnt = PW'(1);
                  nextGoodCnt  = '0;
               end else begin
                  nextState    = SEARCH;
               end
            end else if ((state == ACQUIRE) && (phaseCnt == LAST_PHASE)) begin
               nextGoodCnt = goodCnt + GW'(1);
               if ((goodCnt + GW'(1)) == GOOD_TARGET) begin
                  nextState = LOCKED;
               end else begin
                  nextState = ACQUIRE;
               end
            end else begin
               nextState = state;
            end
         end
         default: begin
            nextState = SEARCH;
         end
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clkX4) begin
      if (rst) begin
         state      <= SEARCH;
         phaseCnt   <= '0;
         goodCnt    <= '0;
         phase      <= '0;
         risePulse  <= 1'b0;
         fallPulse  <= 1'b0;
         locked     <= 1'b0;
         errorPulse <= 1'b0;
         errCount   <= 8'h00;
      end else begin
         state      <= nextState;
         phaseCnt   <= nextPhaseCnt;
         goodCnt    <= nextGoodCnt;
         phase      <= reportPhase;
         risePulse  <= rise;
         fallPulse  <= fall;
         locked     <= (nextState == LOCKED);
         errorPulse <= lockErr;
         errCount   <= lockErr ? satInc8(errCount) : errCount;
      end
   end

endmodule
